nature2grey_gen: RTL
====================

Name: nature2grey_gen

Overview:
- Binary-to-Gray ("nature to grey") encoder with a registered output. It is the transmit-side counterpart to the grey2nature decoder.
- Two source modes:
  - Mode 0 converts an external binary word.
  - Mode 1 runs an internal binary counter and emits its Gray code, so it can directly drive a grey2nature instance.
- A built-in hop monitor flags any emitted transition that changes more than one bit.

Parameters:
WIDTH, 4, bit width of the binary input, the internal counter and the Gray output (WIDTH >= 2).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  advance/convert enable, sampled on rising edge of clk
mode  input  1  source select: 0 = external nature input, 1 = internal counter
nature  input  WIDTH  binary value to encode (used when mode=0)
grey  output  WIDTH  registered Gray code, grey = src ^ (src >> 1)
grey_vld  output  1  high for the cycle after an accepted en (new grey value present)
hop_err  output  1  one-cycle pulse: latest grey differs from the previous output in more than one bit

Behaviour:
- Reset (rst_n=0, async):
  - grey=0, grey_vld=0, hop_err=0.
  - Internal counter cnt=0; internal have_prev=0.
  - A reset asserted mid-stream clears all of these immediately, without waiting for clk.
  - After rst_n deasserts, the first en cycle is treated as the first output.
- Source word: src = (mode ? cnt : nature).
- Rising edge with en=1:
  - grey <= src ^ (src >> 1). Latency is 1 cycle.
  - grey_vld <= 1.
  - If mode=1: cnt <= cnt + 1, modulo 2^WIDTH (wraps from all-ones to 0).
  - If mode=0: cnt <= nature + 1, modulo 2^WIDTH. A following switch to mode 1 therefore continues the sequence seamlessly, with no hop.
  - have_prev <= 1.
- Rising edge with en=0:
  - grey and cnt hold.
  - grey_vld <= 0.
  - hop_err <= 0.
- Hop monitor, evaluated on each en=1 edge:
  - d = (new grey) XOR (current grey register).
  - hop_err <= 1 iff have_prev=1 and popcount(d) > 1; otherwise 0.
  - popcount(d) = 0 (repeated value) and popcount(d) = 1 are legal.
  - hop_err is a single-cycle pulse; it is not sticky.
  - The first output after reset never flags, because have_prev=0.
- Counter wrap: cnt all-ones -> 0 gives Gray 100..0 -> 00..0, a single-bit change, so hop_err stays 0.
- mode may change on any cycle; it takes effect on the same edge it is sampled on.
- Purely synchronous datapath apart from the async reset. No combinational path from inputs to outputs.

Test Plan:
- WIDTH=4, reset, then mode=0, en=1, nature=4'd5 for one cycle -> next cycle grey=4'b0111, grey_vld=1, hop_err=0.
- mode=1 from reset, en=1 for 17 cycles -> grey sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; hop_err=0 throughout, including the wrap.
- mode=0, nature=0 then nature=5 on consecutive en cycles -> grey 0000 then 0111; hop_err=1 for exactly one cycle (3-bit hop). Then nature=7 -> grey 0100; 0111 -> 0100 is a 2-bit change, so hop_err=1 again.
- mode=0, nature=6 (grey 0101), then switch to mode=1 -> next outputs 0100 (7), 1100 (8); hop_err stays 0.
- Mode 1 running, en dropped low for 3 cycles -> grey holds, grey_vld=0, cnt holds. Re-raising en resumes at the next Gray value.
- Assert rst_n=0 mid-count, asynchronously between edges -> grey, grey_vld and hop_err go to 0 immediately. After release, the first en cycle outputs grey=0000 with hop_err=0.

Source files
------------

// File: rtl/nature2grey_gen.sv
// Binary-to-Gray encoder with registered output, an optional internal counter source
// and a monitor that pulses when an emitted code differs from the last in more than one bit.
module nature2grey_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] nature,
  output logic [WIDTH-1:0] grey,
  output logic             grey_vld,
  output logic             hop_err
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] grey_q, grey_d;
  logic             vld_q, vld_d;
  logic             hop_q, hop_d;
  logic             have_prev_q, have_prev_d;

  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] src_grey;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  assign src      = mode ? cnt_q : nature;
  assign src_grey = src ^ (src >> 1);
  assign diff     = src_grey ^ grey_q;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_bit = |(diff & (diff - WIDTH'(1)));

  always_comb begin
    cnt_d       = cnt_q;
    grey_d      = grey_q;
    vld_d       = 1'b0;
    hop_d       = 1'b0;
    have_prev_d = have_prev_q;
    if (en) begin
      grey_d      = src_grey;
      vld_d       = 1'b1;
      hop_d       = have_prev_q & multi_bit;
      have_prev_d = 1'b1;
      // Seeding from the external word lets a later switch to mode 1 continue without a hop.
      cnt_d       = src + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      grey_q      <= '0;
      vld_q       <= 1'b0;
      hop_q       <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      grey_q      <= grey_d;
      vld_q       <= vld_d;
      hop_q       <= hop_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign grey     = grey_q;
  assign grey_vld = vld_q;
  assign hop_err  = hop_q;

endmodule
